// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips16_pkg
// Description : Shared types and constants for the 16-bit multicycle MIPS core
//               and its memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips16_pkg;

    localparam int c_default_data_w = 16;
    localparam int c_default_addr_w = 16;

    // Opcode field is the top nibble of the 16-bit instruction word
    localparam logic [3:0] c_op_rtype = 4'h0;
    localparam logic [3:0] c_op_lw    = 4'h4;
    localparam logic [3:0] c_op_sw    = 4'h5;
    localparam logic [3:0] c_op_beq   = 4'h6;
    localparam logic [3:0] c_op_addi  = 4'h7;
    localparam logic [3:0] c_op_j     = 4'h8;

    localparam logic [2:0] c_funct_add = 3'd0;
    localparam logic [2:0] c_funct_sub = 3'd1;
    localparam logic [2:0] c_funct_and = 3'd2;
    localparam logic [2:0] c_funct_or  = 3'd3;
    localparam logic [2:0] c_funct_slt = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module      : word_ram
// Description : Single-port synchronous word RAM with registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module word_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with programmable wait
//               states, word storage and misalign/range error decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mips16_pkg::*;
#(
    parameter int ADDR_W      = c_default_addr_w,
    parameter int DATA_W      = c_default_data_w,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              c_ram_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);

    mem_state_t        r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_idle;
    logic              w_accept;
    logic              w_commit;
    logic              w_cur_write;
    logic              w_cur_err;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [DATA_W-1:0] w_cur_wdata;
    logic [ADDR_W-2:0] w_cur_idx;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    // In IDLE the live request is used so a zero-wait access commits on its acceptance edge
    assign w_idle      = (r_state == IDLE);
    assign w_cur_write = w_idle ? req_write : r_write;
    assign w_cur_addr  = w_idle ? req_addr  : r_addr;
    assign w_cur_wdata = w_idle ? req_wdata : r_wdata;
    assign w_cur_idx   = w_cur_addr[ADDR_W-1:1];
    assign w_cur_err   = w_cur_addr[0] | ({2'b00, w_cur_idx} >= c_depth);

    assign w_accept = rst & w_idle & req_valid;
    assign w_commit = (w_accept & (WAIT_CYCLES == 0))
                    | (rst & (r_state == WAIT) & (r_cnt == 4'd0));
    assign w_ram_we = w_commit & w_cur_write & ~w_cur_err;

    word_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (c_ram_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_cur_idx[c_ram_aw-1:0]),
        .wdata (w_cur_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_err   <= w_cur_err;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_wait_load;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset directly so it rises in the first cycle after release
    assign req_ready = rst & w_idle;
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid & ~r_err & ~r_write) ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench: three responders (0, 1 and 3 wait states)
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int WC [3] = '{1, 0, 3};

    logic        clk;
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  ready;
    logic [2:0]  rsp_v;
    logic [2:0]  rsp_e;
    logic        t_wr   [3];
    logic [15:0] t_addr [3];
    logic [15:0] t_wd   [3];
    logic [15:0] rsp_d  [3];

    int errors;
    int checks;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_write(t_wr[0]), .req_addr(t_addr[0]),
        .req_wdata(t_wd[0]), .req_ready(ready[0]), .rsp_valid(rsp_v[0]), .rsp_rdata(rsp_d[0]),
        .rsp_err(rsp_e[0]));
    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_write(t_wr[1]), .req_addr(t_addr[1]),
        .req_wdata(t_wd[1]), .req_ready(ready[1]), .rsp_valid(rsp_v[1]), .rsp_rdata(rsp_d[1]),
        .rsp_err(rsp_e[1]));
    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_write(t_wr[2]), .req_addr(t_addr[2]),
        .req_wdata(t_wd[2]), .req_ready(ready[2]), .rsp_valid(rsp_v[2]), .rsp_rdata(rsp_d[2]),
        .rsp_err(rsp_e[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          edge_no;
    int          free_e   [3];
    int          rsp_edge [3];
    bit          pend     [3];
    bit          p_wr     [3];
    bit          p_err    [3];
    int          p_idx    [3];
    logic [15:0] p_wd     [3];
    logic [15:0] exp_d    [3];
    bit          exp_known[3];
    logic [15:0] m_mem    [3][256];
    bit          m_known  [3][256];
    int          rsp_cnt  [3];

    initial begin
        edge_no = 0;
        for (int d = 0; d < 3; d++) begin
            free_e[d] = 0; rsp_edge[d] = -10; pend[d] = 0; rsp_cnt[d] = 0;
            for (int i = 0; i < 256; i++) m_known[d][i] = 0;
        end
    end

    always @(posedge clk) begin
        edge_no++;
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                pend[d]   = 0;
                free_e[d] = 0;
            end else begin
                if (pend[d] && edge_no > rsp_edge[d]) pend[d] = 0;
                if (vld[d] && edge_no >= free_e[d]) begin
                    pend[d]     = 1;
                    p_wr[d]     = t_wr[d];
                    p_wd[d]     = t_wd[d];
                    p_idx[d]    = int'(t_addr[d]) / 2;
                    p_err[d]    = t_addr[d][0] || (p_idx[d] >= 256);
                    rsp_edge[d] = edge_no + WC[d];
                    free_e[d]   = edge_no + WC[d] + 2;
                end
                if (pend[d] && edge_no == rsp_edge[d]) begin
                    if (p_wr[d] && !p_err[d]) begin
                        m_mem[d][p_idx[d]]   = p_wd[d];
                        m_known[d][p_idx[d]] = 1;
                    end
                    if (p_wr[d] || p_err[d]) begin
                        exp_d[d]     = 16'h0;
                        exp_known[d] = 1;
                    end else begin
                        exp_d[d]     = m_mem[d][p_idx[d]];
                        exp_known[d] = m_known[d][p_idx[d]];
                    end
                end
            end
        end
    end

    bit e_rdy;
    bit e_rsp;

    always begin
        @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            e_rdy = rst && (edge_no >= free_e[d] - 1);
            e_rsp = rst && pend[d] && (edge_no == rsp_edge[d]);
            chk("cyc_ready", d, ready[d], e_rdy);
            chk("cyc_rsp_valid", d, rsp_v[d], e_rsp);
            chk("cyc_rsp_err", d, rsp_e[d], e_rsp && p_err[d]);
            if (!e_rsp || exp_known[d])
                chk("cyc_rsp_rdata", d, rsp_d[d], e_rsp ? exp_d[d] : 16'h0);
            if (rsp_v[d]) rsp_cnt[d]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          input bit scramble, output logic [15:0] rd, output bit er, output int lat);
        int  n;
        bit  rdy1;
        bit  seen;
        rd = 16'h0; er = 0; lat = -1; seen = 0;
        @(negedge clk);
        t_wr[d] = wr; t_addr[d] = a; t_wd[d] = wd; vld[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", d, ready[d], 1);
        @(negedge clk);
        vld[d] = 1'b0;
        if (scramble) begin
            t_addr[d] = a ^ 16'h0002;
            t_wd[d]   = ~wd;
        end
        rdy1 = ready[d];
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_v[d]) begin
                seen = 1; lat = k; rd = rsp_d[d]; er = rsp_e[d];
            end
        end
        chk("rsp_seen", d, seen, 1);
        @(negedge clk);
        chk("ready_low_after_accept", d, rdy1, 0);
        chk("ready_after_resp", d, ready[d], 1);
    endtask

    function automatic logic [15:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 16'(($urandom_range(0, 15) << 1) | 1);
        if (sel == 1) return 16'(16'h0200 + ($urandom_range(0, 255) << 1));
        return 16'($urandom_range(0, 15) << 1);
    endfunction

    logic [15:0] rd;
    bit          er;
    int          lat;
    int          pos [$];
    bit          acc_prev [3];

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        vld = 3'b000;
        for (int d = 0; d < 3; d++) begin
            t_wr[d] = 0; t_addr[d] = 16'h0; t_wd[d] = 16'h0; acc_prev[d] = 0;
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", d, ready[d], 0);
            chk("reset_rsp_valid", d, rsp_v[d], 0);
            chk("reset_rdata", d, rsp_d[d], 0);
            chk("reset_err", d, rsp_e[d], 0);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("ready_on_release", d, ready[d], 1);

        // Initialise the word range used by all later reads
        for (int i = 0; i < 48; i++) do_req(0, 1, 16'(i * 2), 16'($urandom), 0, rd, er, lat);
        for (int i = 0; i < 16; i++) begin
            do_req(1, 1, 16'(i * 2), 16'($urandom), 0, rd, er, lat);
            do_req(2, 1, 16'(i * 2), 16'($urandom), 0, rd, er, lat);
        end

        // Write then read, one wait state
        do_req(0, 1, 16'h0010, 16'hBEEF, 0, rd, er, lat);
        chk("wr_err", 0, er, 0);
        chk("wr_rdata_zero", 0, rd, 16'h0);
        do_req(0, 0, 16'h0010, 16'h0000, 0, rd, er, lat);
        chk("rd_beef", 0, rd, 16'hBEEF);
        chk("rd_beef_err", 0, er, 0);
        chk("latency_w1", 0, lat, 2);

        // Zero wait states
        do_req(1, 1, 16'h0006, 16'h1357, 0, rd, er, lat);
        do_req(1, 0, 16'h0006, 16'h0000, 0, rd, er, lat);
        chk("rd_w0", 1, rd, 16'h1357);
        chk("latency_w0", 1, lat, 1);

        // Error handling
        do_req(0, 0, 16'h0003, 16'h0000, 0, rd, er, lat);
        chk("odd_err", 0, er, 1);
        chk("odd_rdata", 0, rd, 16'h0);
        do_req(0, 1, 16'h0000, 16'h0F0F, 0, rd, er, lat);
        do_req(0, 1, 16'h0200, 16'hDEAD, 0, rd, er, lat);
        chk("range_err", 0, er, 1);
        do_req(0, 0, 16'h0000, 16'h0000, 0, rd, er, lat);
        chk("range_no_write", 0, rd, 16'h0F0F);
        chk("range_no_write_err", 0, er, 0);

        // Held request, three wait states
        @(negedge clk);
        t_wr[2] = 0; t_addr[2] = 16'h0004; vld[2] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 20) vld[2] = 1'b0;
            if (rsp_v[2]) pos.push_back(k);
        end
        chk("held_count", 2, pos.size(), 4);
        for (int i = 1; i < pos.size(); i++) chk("held_spacing", 2, pos[i] - pos[i-1], 5);

        // Reset during WAIT aborts an uncommitted write
        do_req(0, 1, 16'h0020, 16'hAAAA, 0, rd, er, lat);
        t_wr[0] = 1; t_addr[0] = 16'h0020; t_wd[0] = 16'h1234; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_rsp_in_reset", 0, rsp_v[0], 0);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 0, rsp_v[0], 0);
        end
        do_req(0, 0, 16'h0020, 16'h0000, 0, rd, er, lat);
        chk("abort_keeps_old", 0, rd, 16'hAAAA);

        // Inputs changing after acceptance are ignored
        do_req(0, 1, 16'h0042, 16'h1111, 0, rd, er, lat);
        do_req(0, 1, 16'h0040, 16'h5A5A, 1, rd, er, lat);
        do_req(0, 0, 16'h0040, 16'h0000, 1, rd, er, lat);
        chk("hold_captured", 0, rd, 16'h5A5A);
        do_req(0, 0, 16'h0042, 16'h0000, 0, rd, er, lat);
        chk("hold_neighbour", 0, rd, 16'h1111);

        // Randomised traffic on all three responders, with one reset pulse
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 300) rst = 1'b0;
            if (c == 303) rst = 1'b1;
            #1;
            for (int d = 0; d < 3; d++) begin
                if (acc_prev[d] || !vld[d]) begin
                    vld[d] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 3) != 0) begin
                        t_wr[d]   = $urandom_range(0, 1) == 1;
                        t_addr[d] = rand_addr();
                        t_wd[d]   = 16'($urandom);
                    end
                end
                acc_prev[d] = vld[d] && ready[d] && rst;
            end
        end
        @(negedge clk);
        vld = 3'b000;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
